// File: rtl/fft_sched_pkg.sv
// fft_sched_pkg: shared FSM state type and radix-2 DIT index helpers for the FFT butterfly scheduler
package fft_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  function automatic int bit_reverse(input int idx, input int n_bits);
    int r = 0;
    for (int i = 0; i < n_bits; i++) r = r | (((idx >> i) & 1) << (n_bits - 1 - i));
    return r;
  endfunction
  function automatic int top_idx(input int s, input int b);
    return ((b >> s) << (s + 1)) + (b & ((1 << s) - 1));
  endfunction
  function automatic int bot_idx(input int s, input int b);
    return top_idx(s, b) + (1 << s);
  endfunction
  function automatic int tw_idx(input int s, input int b, input int n);
    return (b & ((1 << s) - 1)) * (n >> (s + 1));
  endfunction
endpackage

// File: rtl/fft_bfly_addr_gen.sv
// fft_bfly_addr_gen: combinational operand/twiddle addressing for butterfly b of stage s
//   i_stage, i_bfly : stage and butterfly counters
//   o_top, o_bot    : buffer indices of the top (a) and bottom (b) operands
//   o_tw_idx        : twiddle exponent k of W_N^k
module fft_bfly_addr_gen import fft_sched_pkg::*; #(
  parameter int N_SAMPLES = 8
) (
  input  logic [$clog2($clog2(N_SAMPLES))-1:0] i_stage,
  input  logic [$clog2(N_SAMPLES)-2:0]         i_bfly,
  output logic [$clog2(N_SAMPLES)-1:0]         o_top,
  output logic [$clog2(N_SAMPLES)-1:0]         o_bot,
  output logic [$clog2(N_SAMPLES)-2:0]         o_tw_idx
);
  localparam int LOG_N = $clog2(N_SAMPLES);
  assign o_top    = LOG_N'(top_idx(int'(i_stage), int'(i_bfly)));
  assign o_bot    = LOG_N'(bot_idx(int'(i_stage), int'(i_bfly)));
  assign o_tw_idx = (LOG_N - 1)'(tw_idx(int'(i_stage), int'(i_bfly), N_SAMPLES));
endmodule

// File: rtl/fft_bfly_scheduler.sv
// fft_bfly_scheduler: iterative radix-2 DIT FFT sequencer sharing one external butterfly unit
//   i_recv_*   : input frame (natural order, flattened word i at [i*BIT_WIDTH +: BIT_WIDTH]), val/rdy
//   o_bfly_*   : operand request a/b (real r, imag c) and twiddle index, val/rdy
//   i_bfly_*   : butterfly results c (top) / d (bottom), val/rdy
//   o_send_*   : finished spectrum in natural bin order, val/rdy
//   o_busy     : high while butterflies are being scheduled
module fft_bfly_scheduler import fft_sched_pkg::*; #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [BIT_WIDTH*N_SAMPLES-1:0] i_recv_msg_real,
  input  logic [BIT_WIDTH*N_SAMPLES-1:0] i_recv_msg_imag,
  input  logic                           i_recv_val,
  output logic                           o_recv_rdy,
  output logic [BIT_WIDTH-1:0]           o_bfly_ar,
  output logic [BIT_WIDTH-1:0]           o_bfly_ac,
  output logic [BIT_WIDTH-1:0]           o_bfly_br,
  output logic [BIT_WIDTH-1:0]           o_bfly_bc,
  output logic [$clog2(N_SAMPLES)-2:0]   o_bfly_tw_idx,
  output logic                           o_bfly_req_val,
  input  logic                           i_bfly_req_rdy,
  input  logic [BIT_WIDTH-1:0]           i_bfly_cr,
  input  logic [BIT_WIDTH-1:0]           i_bfly_cc,
  input  logic [BIT_WIDTH-1:0]           i_bfly_dr,
  input  logic [BIT_WIDTH-1:0]           i_bfly_dc,
  input  logic                           i_bfly_resp_val,
  output logic                           o_bfly_resp_rdy,
  output logic [BIT_WIDTH*N_SAMPLES-1:0] o_send_msg_real,
  output logic [BIT_WIDTH*N_SAMPLES-1:0] o_send_msg_imag,
  output logic                           o_send_val,
  input  logic                           i_send_rdy,
  output logic                           o_busy
);
  localparam int LOG_N = $clog2(N_SAMPLES);
  localparam int SW = $clog2(LOG_N);
  localparam logic [SW-1:0] ST_LAST = SW'(LOG_N - 1);
  localparam logic [LOG_N-2:0] BF_LAST = '1;
  state_t r_state, w_next;
  logic [BIT_WIDTH-1:0] r_re [N_SAMPLES];
  logic [BIT_WIDTH-1:0] r_im [N_SAMPLES];
  logic [SW-1:0] r_stage;
  logic [LOG_N-2:0] r_bfly;
  logic [LOG_N-1:0] w_top, w_bot;
  logic w_load, w_wb, w_last;

  fft_bfly_addr_gen #(.N_SAMPLES(N_SAMPLES)) u_addr (
    .i_stage  (r_stage),
    .i_bfly   (r_bfly),
    .o_top    (w_top),
    .o_bot    (w_bot),
    .o_tw_idx (o_bfly_tw_idx)
  );

  assign o_bfly_ar = r_re[w_top];
  assign o_bfly_ac = r_im[w_top];
  assign o_bfly_br = r_re[w_bot];
  assign o_bfly_bc = r_im[w_bot];

  for (genvar g = 0; g < N_SAMPLES; g++) begin : g_out
    assign o_send_msg_real[g*BIT_WIDTH +: BIT_WIDTH] = r_re[g];
    assign o_send_msg_imag[g*BIT_WIDTH +: BIT_WIDTH] = r_im[g];
  end

  always_comb begin
    w_load = r_state == IDLE && i_recv_val;
    w_wb   = r_state == WAIT && i_bfly_resp_val;
    w_last = r_stage == ST_LAST && r_bfly == BF_LAST;
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_recv_val ? ISSUE : IDLE;
      ISSUE:   w_next = i_bfly_req_rdy ? WAIT : ISSUE;
      WAIT:    w_next = i_bfly_resp_val ? (w_last ? DONE : ISSUE) : WAIT;
      default: w_next = i_send_rdy ? IDLE : DONE;
    endcase
    // recv_rdy is gated by the reset pin so it reads 0 throughout reset, not just after the edge
    o_recv_rdy      = i_rst_n && r_state == IDLE;
    o_bfly_req_val  = r_state == ISSUE;
    o_bfly_resp_rdy = r_state == WAIT;
    o_send_val      = r_state == DONE;
    o_busy          = r_state == ISSUE || r_state == WAIT;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_stage <= '0;
      r_bfly  <= '0;
      for (int i = 0; i < N_SAMPLES; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_stage <= '0;
        r_bfly  <= '0;
        for (int i = 0; i < N_SAMPLES; i++) begin
          r_re[LOG_N'(bit_reverse(i, LOG_N))] <= i_recv_msg_real[i*BIT_WIDTH +: BIT_WIDTH];
          r_im[LOG_N'(bit_reverse(i, LOG_N))] <= i_recv_msg_imag[i*BIT_WIDTH +: BIT_WIDTH];
        end
      end
      if (w_wb) begin
        r_re[w_top] <= i_bfly_cr;
        r_im[w_top] <= i_bfly_cc;
        r_re[w_bot] <= i_bfly_dr;
        r_im[w_bot] <= i_bfly_dc;
        // bfly counter is LOG_N-1 bits wide, so it wraps to 0 after N/2-1 on its own
        r_bfly <= r_bfly + (LOG_N - 1)'(1);
        if (r_bfly == BF_LAST) r_stage <= w_last ? '0 : r_stage + SW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// tb_fft_bfly_scheduler: directed table-driven bench for the FFT butterfly scheduler
module tb_fft_bfly_scheduler;
  localparam int BW = 32;
  localparam int N = 8;
  logic clk = 0;
  logic rst_n = 0;
  logic [BW*N-1:0] i_recv_msg_real = '0, i_recv_msg_imag = '0;
  logic i_recv_val = 0, o_recv_rdy;
  logic [BW-1:0] o_bfly_ar, o_bfly_ac, o_bfly_br, o_bfly_bc;
  logic [1:0] o_bfly_tw_idx;
  logic o_bfly_req_val, i_bfly_req_rdy = 0;
  logic [BW-1:0] i_bfly_cr = '0, i_bfly_cc = '0, i_bfly_dr = '0, i_bfly_dc = '0;
  logic i_bfly_resp_val = 0, o_bfly_resp_rdy;
  logic [BW*N-1:0] o_send_msg_real, o_send_msg_imag;
  logic o_send_val, i_send_rdy = 0, o_busy;

  typedef struct { int ar; int br; int tw; } vec_t;
  vec_t tv [12];
  int br_tab [8];
  int wr [4];
  int wi [4];
  int f_re [8], f_im [8], x_re [8], x_im [8];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  fft_bfly_scheduler #(.BIT_WIDTH(BW), .N_SAMPLES(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_recv_msg_real(i_recv_msg_real), .i_recv_msg_imag(i_recv_msg_imag),
    .i_recv_val(i_recv_val), .o_recv_rdy(o_recv_rdy),
    .o_bfly_ar(o_bfly_ar), .o_bfly_ac(o_bfly_ac), .o_bfly_br(o_bfly_br), .o_bfly_bc(o_bfly_bc),
    .o_bfly_tw_idx(o_bfly_tw_idx), .o_bfly_req_val(o_bfly_req_val), .i_bfly_req_rdy(i_bfly_req_rdy),
    .i_bfly_cr(i_bfly_cr), .i_bfly_cc(i_bfly_cc), .i_bfly_dr(i_bfly_dr), .i_bfly_dc(i_bfly_dc),
    .i_bfly_resp_val(i_bfly_resp_val), .o_bfly_resp_rdy(o_bfly_resp_rdy),
    .o_send_msg_real(o_send_msg_real), .o_send_msg_imag(o_send_msg_imag),
    .o_send_val(o_send_val), .i_send_rdy(i_send_rdy), .o_busy(o_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, $signed(act), act, $signed(exp), exp);
    end
  endtask

  function automatic logic any_out();
    return |{o_recv_rdy, o_bfly_ar, o_bfly_ac, o_bfly_br, o_bfly_bc, o_bfly_tw_idx, o_bfly_req_val,
             o_bfly_resp_rdy, o_send_msg_real, o_send_msg_imag, o_send_val, o_busy};
  endfunction

  task automatic drive_frame();
    for (int i = 0; i < N; i++) begin
      i_recv_msg_real[i*BW +: BW] = f_re[i];
      i_recv_msg_imag[i*BW +: BW] = f_im[i];
    end
    i_recv_val = 1;
  endtask

  // mode 0: butterfly returns its operands; mode 1: Q16.16 DIT butterfly c=a+Wb, d=a-Wb
  task automatic run_frame(input int mode, input int req_hold, input int resp_hold,
                           input bit trace, input bit noise, input int send_hold);
    int n_req = 0, cyc = 0, hold = 0, rwait = 0, guard = 0;
    int a_r, a_i, b_r, b_i;
    longint pr, pim;
    logic [BW-1:0] s_ar, s_ai, s_br, s_bi, p_cr, p_cc, p_dr, p_dc;
    logic [1:0] s_tw;
    logic [BW*N-1:0] cap_re, cap_im;
    while (!o_recv_rdy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("recv_rdy_before_frame", o_recv_rdy, 1);
    drive_frame();
    while (!o_send_val && cyc < 400) begin
      @(negedge clk);
      cyc++;
      i_recv_val = noise;
      if (noise) begin
        i_recv_msg_real = '1;
        i_recv_msg_imag = '1;
        i_send_rdy = 1;
      end
      i_bfly_req_rdy = 0;
      i_bfly_resp_val = 0;
      if (hold > 0 && !o_bfly_req_val) begin
        chk("req_val_held", o_bfly_req_val, 1);
        hold = 0;
      end
      if (o_bfly_req_val) begin
        if (hold == 0) begin
          s_ar = o_bfly_ar; s_ai = o_bfly_ac; s_br = o_bfly_br; s_bi = o_bfly_bc; s_tw = o_bfly_tw_idx;
          if (trace && n_req < 12) begin
            chk($sformatf("req%0d_ar", n_req), s_ar, tv[n_req].ar);
            chk($sformatf("req%0d_br", n_req), s_br, tv[n_req].br);
            chk($sformatf("req%0d_tw", n_req), s_tw, tv[n_req].tw);
            chk($sformatf("req%0d_ai", n_req), s_ai, tv[n_req].ar + 8);
            chk($sformatf("req%0d_bi", n_req), s_bi, tv[n_req].br + 8);
          end
        end else begin
          chk("hold_ar", o_bfly_ar, s_ar);
          chk("hold_ai", o_bfly_ac, s_ai);
          chk("hold_br", o_bfly_br, s_br);
          chk("hold_bi", o_bfly_bc, s_bi);
          chk("hold_tw", o_bfly_tw_idx, s_tw);
        end
        if (hold >= req_hold) begin
          i_bfly_req_rdy = 1;
          a_r = s_ar; a_i = s_ai; b_r = s_br; b_i = s_bi;
          pr  = (longint'(b_r) * wr[s_tw] - longint'(b_i) * wi[s_tw]) >>> 16;
          pim = (longint'(b_r) * wi[s_tw] + longint'(b_i) * wr[s_tw]) >>> 16;
          p_cr = mode == 1 ? a_r + int'(pr) : s_ar;
          p_cc = mode == 1 ? a_i + int'(pim) : s_ai;
          p_dr = mode == 1 ? a_r - int'(pr) : s_br;
          p_dc = mode == 1 ? a_i - int'(pim) : s_bi;
          hold = 0;
          rwait = 0;
          n_req++;
        end else begin
          hold++;
          if (noise) begin
            i_bfly_resp_val = 1;
            i_bfly_cr = 32'hDEAD_0001; i_bfly_cc = 32'hDEAD_0002;
            i_bfly_dr = 32'hDEAD_0003; i_bfly_dc = 32'hDEAD_0004;
          end
        end
      end else if (o_bfly_resp_rdy) begin
        if (rwait >= resp_hold) begin
          i_bfly_resp_val = 1;
          i_bfly_cr = p_cr; i_bfly_cc = p_cc; i_bfly_dr = p_dr; i_bfly_dc = p_dc;
        end else begin
          chk("resp_wait_busy", o_busy, 1);
          rwait++;
        end
      end
    end
    i_recv_val = 0;
    chk("send_val_seen", o_send_val, 1);
    chk("n_requests", n_req, 12);
    if (req_hold == 0 && resp_hold == 0) chk("send_val_cycle", cyc, 25);
    cap_re = o_send_msg_real;
    cap_im = o_send_msg_imag;
    for (int j = 0; j < N; j++) begin
      chk($sformatf("bin%0d_re", j), cap_re[j*BW +: BW], x_re[j]);
      chk($sformatf("bin%0d_im", j), cap_im[j*BW +: BW], x_im[j]);
    end
    for (int h = 0; h < send_hold; h++) begin
      i_send_rdy = 0;
      @(negedge clk);
      chk("send_val_held", o_send_val, 1);
      chk("recv_rdy_in_done", o_recv_rdy, 0);
      chk("send_data_held", o_send_msg_real == cap_re && o_send_msg_imag == cap_im, 1);
    end
    i_send_rdy = 1;
    @(negedge clk);
    i_send_rdy = 0;
    chk("post_send_val", o_send_val, 0);
    chk("post_send_recv_rdy", o_recv_rdy, 1);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < N; i++) begin
      f_re[i] = i; f_im[i] = 8 + i;
      x_re[i] = br_tab[i]; x_im[i] = 8 + br_tab[i];
    end
  endtask

  task automatic set_impulse();
    for (int i = 0; i < N; i++) begin
      f_re[i] = i == 0 ? 65536 : 0; f_im[i] = 0;
      x_re[i] = 65536; x_im[i] = 0;
    end
  endtask

  initial begin
    tv[0] = '{0, 4, 0}; tv[1] = '{2, 6, 0}; tv[2] = '{1, 5, 0}; tv[3] = '{3, 7, 0};
    tv[4] = '{0, 2, 0}; tv[5] = '{4, 6, 2}; tv[6] = '{1, 3, 0}; tv[7] = '{5, 7, 2};
    tv[8] = '{0, 1, 0}; tv[9] = '{4, 5, 1}; tv[10] = '{2, 3, 2}; tv[11] = '{6, 7, 3};
    br_tab = '{0, 4, 2, 6, 1, 5, 3, 7};
    wr = '{65536, 46341, 0, -46341};
    wi = '{0, -46341, -65536, -46341};
    rst_n = 0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs_zero", any_out(), 0);
    end
    rst_n = 1;
    @(negedge clk);
    chk("idle_recv_rdy", o_recv_rdy, 1);
    chk("idle_busy", o_busy, 0);
    set_ramp();
    run_frame(0, 0, 0, 1, 0, 5);
    set_impulse();
    run_frame(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      f_re[i] = 65536; f_im[i] = 0;
      x_re[i] = i == 0 ? 524288 : 0; x_im[i] = 0;
    end
    run_frame(1, 0, 0, 0, 0, 0);
    set_ramp();
    run_frame(0, 3, 4, 1, 1, 0);
    set_impulse();
    drive_frame();
    i_bfly_req_rdy = 1;
    i_bfly_resp_val = 1;
    @(negedge clk);
    i_recv_val = 0;
    repeat (9) @(negedge clk);
    chk("mid_in_wait", o_bfly_resp_rdy, 1);
    chk("mid_busy", o_busy, 1);
    i_bfly_cr = 32'h1234_5678; i_bfly_cc = 32'h1234_5678;
    i_bfly_dr = 32'h1234_5678; i_bfly_dc = 32'h1234_5678;
    #2 rst_n = 0;
    #1 chk("async_reset_outputs_zero", any_out(), 0);
    @(negedge clk);
    chk("held_reset_outputs_zero", any_out(), 0);
    i_bfly_req_rdy = 0;
    i_bfly_resp_val = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("after_reset_busy", o_busy, 0);
    run_frame(1, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_bfly_scheduler.md
Name: fft_bfly_scheduler

Overview:
- Iterative radix-2 DIT FFT sequencer that time-shares one external butterfly unit (val/rdy, multi-cycle) across all N/2·log2(N) butterflies of a frame.
- Holds a frame in an internal complex sample buffer, loads it in bit-reversed order, and schedules each butterfly's operand pair and twiddle index.
- Writes each result back in place and presents the finished spectrum.
- Sits between the sample front-end and downstream magnitude/classifier logic, as the low-area alternative to the fully unrolled per-stage FFT pipeline.

Parameters:
BIT_WIDTH, 32, width of each real/imag word (fixed-point; passed through unmodified)
N_SAMPLES, 8, FFT size; power of two, >= 4
LOG_N, $clog2(N_SAMPLES), localparam; number of stages

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
recv_msg_real  in  BIT_WIDTH x N_SAMPLES  input frame, real parts, natural order
recv_msg_imag  in  BIT_WIDTH x N_SAMPLES  input frame, imag parts
recv_val  in  1  input frame valid
recv_rdy  out  1  ready to accept a frame
bfly_ar, bfly_ac, bfly_br, bfly_bc  out  BIT_WIDTH each  butterfly operands a (top), b (bottom)
bfly_tw_idx  out  LOG_N-1  twiddle index k of W_N^k
bfly_req_val  out  1  operand request valid
bfly_req_rdy  in  1  butterfly accepts request
bfly_cr, bfly_cc, bfly_dr, bfly_dc  in  BIT_WIDTH each  results c (top), d (bottom)
bfly_resp_val  in  1  result valid
bfly_resp_rdy  out  1  scheduler accepts result
send_msg_real  out  BIT_WIDTH x N_SAMPLES  output spectrum, real, natural bin order
send_msg_imag  out  BIT_WIDTH x N_SAMPLES  output spectrum, imag
send_val  out  1  spectrum valid
send_rdy  in  1  downstream accepts spectrum
busy  out  1  high in ISSUE/WAIT

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; buffer, stage_cnt and bfly_cnt go to 0.
  - All outputs are 0 while reset is asserted, including recv_rdy.
  - Takes effect mid-frame at any state; the in-flight butterfly result is discarded.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: recv_rdy=1. On recv_val: buf[bitrev(i)] <= recv[i] for all i; stage_cnt=0, bfly_cnt=0; go to ISSUE.
  - ISSUE: bfly_req_val=1; operands and twiddle index are driven from buffer and counters and held stable until bfly_req_rdy. On handshake, go to WAIT.
  - WAIT: bfly_resp_rdy=1. On bfly_resp_val: buf[top] <= (cr,cc), buf[bot] <= (dr,dc), then advance counters.
    - If the last butterfly of the last stage completed, go to DONE; otherwise go to ISSUE.
  - DONE: send_val=1; send_msg driven straight from buf and stable. On send_rdy, go to IDLE.
- Addressing (stage s, butterfly b):
  - half = 1<<s, pos = b & (half-1).
  - top = ((b>>s) << (s+1)) + pos, bot = top + half.
  - tw_idx = pos * (N_SAMPLES >> (s+1)).
- Counter wrap:
  - bfly_cnt == N/2-1 -> 0 and stage_cnt++.
  - Completion when stage_cnt == LOG_N-1 and bfly_cnt == N/2-1.
- Exactly one butterfly in flight; a response is never consumed in the ISSUE cycle.
- Latency: with a butterfly that is always ready and responds one cycle after acceptance, butterfly k issues in cycle 2k+1 after the recv handshake cycle. send_val rises N·LOG_N+1 cycles after the handshake (25 for N=8).
- Ignored inputs:
  - recv_val outside IDLE (recv_rdy=0).
  - bfly_resp_val outside WAIT.
  - send_rdy outside DONE.
- No arithmetic here; scaling and overflow are owned by the butterfly unit. Data width is passed through unchanged.
- Back-to-back frames: IDLE is entered on the send handshake; the next frame is accepted at the earliest one cycle later.

Decomposition:
- Package fft_sched_pkg:
  - state enum (IDLE/ISSUE/WAIT/DONE)
  - function bit_reverse(idx, LOG_N)
  - functions top_idx, bot_idx, tw_idx(stage, bfly, N).
- Sub-module fft_bfly_addr_gen: combinational; stage_cnt and bfly_cnt in, top, bot and tw_idx out. Unit-tested standalone.

Test Plan:
- Reset and idle:
  - Stimulus: hold reset=0 for 3 cycles, then release.
  - Required: all outputs 0 during reset; recv_rdy=1 in the first cycle after release; busy=0.
- Bit-reversed load (N=8):
  - Stimulus: recv_msg_real = 0..7, imag = 0.
  - Required: first request ar=0, br=4, tw_idx=0; second request ar=2, br=6.
- Schedule trace (N=8, ideal 1-cycle butterfly that returns its operands unchanged):
  - Stage 0 pairs: (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0.
  - Stage 1 pairs: (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2.
  - Stage 2 pairs: (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
  - Required: exactly 12 requests; send_val at cycle 25.
- End-to-end with the fixed-point butterfly model (Q16.16):
  - Impulse x[0]=65536 -> every bin real=65536, imag=0.
  - Constant x[i]=65536 -> bin0 real=524288, all other bins 0.
- Backpressure:
  - bfly_req_rdy low for 3 cycles -> bfly_a*/b*/tw_idx stable and bfly_req_val held.
  - bfly_resp_val delayed 4 cycles -> no counter advance.
  - send_rdy low for 5 cycles -> send_val and data held, recv_rdy=0.
- Reset mid-frame:
  - Stimulus: assert reset during stage 1 WAIT.
  - Required: outputs 0 immediately (async); after release a fresh impulse frame completes with the correct spectrum and the stale response is not written.
